huffman_decoder: RTL and testbench
==================================

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: bit_in  input  1  serial code bit, MSB of each codeword first.
REQ-004 SHALL have port: bit_valid  input  1  bit_in carries a valid bit this cycle.
REQ-005 SHALL have port: bit_ready  output  1  decoder accepts a bit this cycle; transfer = bit_valid && bit_ready.
REQ-006 SHALL have port: clr  input  1  synchronous abort; discards any partial codeword.
REQ-007 SHALL have port: sym_out  output  8  decoded ASCII byte (8'h61..8'h7A, 8'h20).
REQ-008 SHALL have port: sym_valid  output  1  sym_out holds an undelivered symbol.
REQ-009 SHALL have port: sym_ready  input  1  sink accepts; symbol transfer = sym_valid && sym_ready.
REQ-010 SHALL have port: err  output  1  one-cycle pulse: invalid codeword, or MAX_LEN bits with no match.
REQ-011 SHALL have port: sym_cnt  output  16  count of symbols transferred to the sink.

Function
REQ-012 SHALL decode with the same static code table as the team's encoder (27 symbols: a..z, space), each entry a code value right-aligned in 8 bits plus a length 1..MAX_LEN.
REQ-013 SHALL hold a shift register acc[7:0] and length counter len[3:0]; on each bit transfer: acc <= {acc[6:0], bit_in}, len <= len+1.
REQ-014 SHALL compare the next-state pair (acc_next, len_next) against all table entries in the same cycle; a match needs equal length and equal value.
REQ-015 On match SHALL register sym_out = matched ASCII byte, set sym_valid, clear acc and len; latency = 1 cycle after the last code bit.
REQ-016 On no match with len_next == MAX_LEN (8) SHALL pulse err for 1 cycle, clear acc and len, produce no symbol.
REQ-017 SHALL drive bit_ready = !sym_valid || sym_ready (combinational from sym_ready), so a new codeword can finish in the same cycle the previous symbol leaves.
REQ-018 SHALL hold sym_out and sym_valid stable while sym_valid && !sym_ready.
REQ-019 SHALL clear sym_valid on a symbol transfer unless a new match completes that same cycle, in which case sym_valid stays 1 and sym_out is updated.
REQ-020 SHALL increment sym_cnt on each symbol transfer, saturating at 16'hFFFF.
REQ-021 clr SHALL clear acc, len and err; it SHALL NOT discard a pending sym_out/sym_valid; a bit transferred in the clr cycle SHALL be discarded.
REQ-022 State machine SHALL have states COLLECT (len==0), PARTIAL (0<len<MAX_LEN) and HOLD (sym_valid && !sym_ready, bit_ready low).
REQ-023 Transitions: COLLECT/PARTIAL -> PARTIAL on a bit with no match; -> COLLECT on match with the symbol taken, on err, or on clr; -> HOLD on match without sym_ready; HOLD -> COLLECT on sym_ready.
REQ-024 Table lookup SHALL rely on the table being prefix-free; the first match by length order wins.

Reset
REQ-025 On rst_n low, asynchronously: sym_out = 8'h00, sym_valid = 0, err = 0, sym_cnt = 0, acc = 0, len = 0, state = COLLECT.
REQ-026 bit_ready SHALL be 1 from the first clock after rst_n deasserts.
REQ-027 Reset asserted mid-codeword SHALL discard the partial codeword and any pending symbol.

Structure
REQ-028 Code values, code lengths, MAX_LEN and the ASCII constants SHALL live in the shared params file also used by the encoder.
REQ-029 Matching SHALL be a combinational sub-module huffman_code_lut (in: value[7:0], len[3:0]; out: hit, ascii[7:0]).
REQ-030 Target size SHALL be 120-400 lines of RTL, with no memories.

Verification
REQ-031 After reset, send the bits of symb_e MSB-first with bit_valid=1 and sym_ready=1 -> sym_out=8'h65 and sym_valid=1 for one cycle, 1 cycle after the last bit; sym_cnt=1.
REQ-032 Stream "a b" (8'h61, 8'h20, 8'h62 codes) back-to-back -> three symbols in order, no gaps beyond code length, err never set.
REQ-033 Hold sym_ready=0 after the first symbol decodes -> bit_ready=0, sym_out holds 8'h61; release -> transfer, bit_ready=1 same cycle.
REQ-034 Send 8 bits matching no codeword -> err=1 for exactly 1 cycle after the 8th bit, no sym_valid, next valid code decodes correctly.
REQ-035 Assert clr after 2 bits of a 4+-bit code, then send a full symb_t -> only 8'h74 output; pull rst_n low mid-codeword -> all outputs 0 asynchronously.
REQ-036 Loop encoder output into the decoder over all 27 symbols -> each output byte equals the encoder input byte.

Source files
------------

// File: rtl/huffman_decoder_pkg.sv
// rtl/huffman_decoder_pkg.sv - shared Huffman code table and constants (encoder and decoder)
package huffman_decoder_pkg;

   localparam int          NUM_SYM     = 27;
   localparam logic [3:0]  MAX_LEN     = 4'd8;
   localparam logic [7:0]  ASCII_A     = 8'h61;
   localparam logic [7:0]  ASCII_Z     = 8'h7A;
   localparam logic [7:0]  ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_PARTIAL,
      ST_HOLD
   } state_e;

   // Entries sorted by code length; values right-aligned. Prefix 10101 is deliberately unused.
   localparam logic [7:0] CODE_ASCII [NUM_SYM] = '{
      8'h20, 8'h65, 8'h74, 8'h61, 8'h6F, 8'h69, 8'h6E, 8'h73, 8'h68,
      8'h72, 8'h64, 8'h6C, 8'h63, 8'h75, 8'h6D, 8'h77, 8'h66, 8'h67,
      8'h79, 8'h70, 8'h62, 8'h76, 8'h6B, 8'h6A, 8'h78, 8'h71, 8'h7A
   };

   localparam logic [7:0] CODE_VAL [NUM_SYM] = '{
      8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h14,
      8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h38, 8'h39, 8'h3A,
      8'h3B, 8'h3C, 8'h3D, 8'h7C, 8'h7D, 8'hFC, 8'hFD, 8'hFE, 8'hFF
   };

   localparam logic [3:0] CODE_LEN [NUM_SYM] = '{
      4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5,
      4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6,
      4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8
   };

endpackage

// File: rtl/huffman_code_lut.sv
// rtl/huffman_code_lut.sv - combinational codeword match against the static table
module huffman_code_lut
   import huffman_decoder_pkg::*;
(
   input  logic [7:0] value,
   input  logic [3:0] len,
   output logic       hit,
   output logic [7:0] ascii
);

   // Table is prefix-free, so the first hit in length order is the only possible one.
   always_comb begin
      hit   = 1'b0;
      ascii = 8'h00;
      for (int i = 0; i < NUM_SYM; i++) begin
         if (!hit && (len == CODE_LEN[i]) && (value == CODE_VAL[i])) begin
            hit   = 1'b1;
            ascii = CODE_ASCII[i];
         end
      end
   end

endmodule

// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial MSB-first Huffman decoder with ready/valid symbol output
module huffman_decoder
   import huffman_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   output logic        bit_ready,
   input  logic        clr,
   output logic [7:0]  sym_out,
   output logic        sym_valid,
   input  logic        sym_ready,
   output logic        err,
   output logic [15:0] sym_cnt
);

   logic [7:0]  acc_q, acc_d;
   logic [3:0]  len_q, len_d;
   logic [7:0]  sym_out_q;
   logic        sym_valid_q;
   logic        err_q;
   logic [15:0] sym_cnt_q;
   logic        rdy_q;
   state_e      state_q;

   logic        bit_fire, sym_fire, match, overflow;
   logic        lut_hit;
   logic [7:0]  lut_ascii;

   // rdy_q keeps bit_ready low while in reset and lets it rise on the first clock after.
   assign bit_ready = rdy_q && (!sym_valid_q || sym_ready);
   assign bit_fire  = bit_valid && bit_ready && !clr;
   assign sym_fire  = sym_valid_q && sym_ready;
   assign acc_d     = {acc_q[6:0], bit_in};
   assign len_d     = len_q + 4'd1;
   assign match     = bit_fire && lut_hit;
   assign overflow  = bit_fire && !lut_hit && (len_d == MAX_LEN);

   huffman_code_lut u_lut (
      .value (acc_d),
      .len   (len_d),
      .hit   (lut_hit),
      .ascii (lut_ascii)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= 8'h00;
         len_q       <= 4'd0;
         sym_out_q   <= 8'h00;
         sym_valid_q <= 1'b0;
         err_q       <= 1'b0;
         sym_cnt_q   <= 16'h0000;
         rdy_q       <= 1'b0;
         state_q     <= ST_COLLECT;
      end else begin
         rdy_q <= 1'b1;
         err_q <= overflow;

         if (sym_fire && (sym_cnt_q != 16'hFFFF))
            sym_cnt_q <= sym_cnt_q + 16'd1;

         if (clr || match || overflow) begin
            acc_q <= 8'h00;
            len_q <= 4'd0;
         end else if (bit_fire) begin
            acc_q <= acc_d;
            len_q <= len_d;
         end

         // A new match in the same cycle as a transfer replaces the outgoing symbol.
         if (match) begin
            sym_out_q   <= lut_ascii;
            sym_valid_q <= 1'b1;
         end else if (sym_fire) begin
            sym_valid_q <= 1'b0;
         end

         if (match)
            state_q <= sym_ready ? ST_COLLECT : ST_HOLD;
         else if ((state_q == ST_HOLD) && !sym_ready)
            state_q <= ST_HOLD;
         else if (clr || overflow)
            state_q <= ST_COLLECT;
         else if (bit_fire)
            state_q <= ST_PARTIAL;
         else if (state_q == ST_HOLD)
            state_q <= ST_COLLECT;
      end
   end

   assign sym_out   = sym_out_q;
   assign sym_valid = sym_valid_q;
   assign err       = err_q;
   assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - directed self-checking bench for huffman_decoder
module tb_huffman_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        clr = 1'b0;
   logic        sym_ready = 1'b1;
   logic        bit_ready;
   logic [7:0]  sym_out;
   logic        sym_valid;
   logic        err;
   logic [15:0] sym_cnt;

   int   checks = 0;
   int   failures = 0;
   logic err_seen = 1'b0;
   logic valid_seen = 1'b0;

   // Codewords as bit strings, alphabetical order a..z then space.
   string codes [27] = '{
      "0101", "111101", "11001", "10111", "001", "111001", "111010", "10100",
      "0111", "11111100", "1111101", "11000", "11011", "1000", "0110", "111100",
      "11111110", "10110", "1001", "0100", "11010", "1111100", "111000",
      "11111101", "111011", "11111111", "000"
   };

   always #5 clk = ~clk;

   huffman_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .clr       (clr),
      .sym_out   (sym_out),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .err       (err),
      .sym_cnt   (sym_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      if (err) err_seen = 1'b1;
      if (sym_valid) valid_seen = 1'b1;
   endtask

   task automatic send_code(input string s);
      for (int i = 0; i < s.len(); i++) send_bit(s[i] == 8'h31);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_ascii;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sym_out", {8'h00, sym_out}, 16'h0000);
      chk("rst_sym_valid", {15'd0, sym_valid}, 16'd0);
      chk("rst_err", {15'd0, err}, 16'd0);
      chk("rst_sym_cnt", sym_cnt, 16'd0);
      chk("rst_bit_ready", {15'd0, bit_ready}, 16'd0);
      rst_n = 1'b1;
      idle();
      chk("post_rst_bit_ready", {15'd0, bit_ready}, 16'd1);

      // Single symbol 'e' = 001
      send_code("00");
      chk("e_partial_valid", {15'd0, sym_valid}, 16'd0);
      send_bit(1'b1);
      chk("e_sym_valid", {15'd0, sym_valid}, 16'd1);
      chk("e_sym_out", {8'h00, sym_out}, 16'h0065);
      idle();
      chk("e_valid_drop", {15'd0, sym_valid}, 16'd0);
      chk("e_cnt", sym_cnt, 16'd1);

      // Back-to-back "a b"
      err_seen = 1'b0;
      send_code("0101");
      chk("str_a", {7'd0, sym_valid, sym_out}, 16'h0161);
      send_code("000");
      chk("str_space", {7'd0, sym_valid, sym_out}, 16'h0120);
      send_code("111101");
      chk("str_b", {7'd0, sym_valid, sym_out}, 16'h0162);
      idle();
      chk("str_err", {15'd0, err_seen}, 16'd0);
      chk("str_cnt", sym_cnt, 16'd4);

      // Backpressure; a bit offered while holding must be ignored
      sym_ready = 1'b0;
      send_code("0101");
      chk("hold_first", {7'd0, sym_valid, sym_out}, 16'h0161);
      chk("hold_bit_ready", {15'd0, bit_ready}, 16'd0);
      bit_in = 1'b1;
      bit_valid = 1'b1;
      idle();
      bit_valid = 1'b0;
      idle();
      chk("hold_stable", {7'd0, sym_valid, sym_out}, 16'h0161);
      chk("hold_cnt", sym_cnt, 16'd4);
      sym_ready = 1'b1;
      #1;
      chk("release_bit_ready", {15'd0, bit_ready}, 16'd1);
      idle();
      chk("release_valid", {15'd0, sym_valid}, 16'd0);
      chk("release_cnt", sym_cnt, 16'd5);

      // clr keeps a pending symbol
      sym_ready = 1'b0;
      send_code("001");
      clr = 1'b1;
      idle();
      clr = 1'b0;
      chk("clr_pending", {7'd0, sym_valid, sym_out}, 16'h0165);
      sym_ready = 1'b1;
      idle();
      chk("clr_pending_cnt", sym_cnt, 16'd6);

      // 8 bits with no matching codeword
      err_seen = 1'b0;
      valid_seen = 1'b0;
      send_code("1010101");
      chk("inv_no_early_err", {15'd0, err_seen}, 16'd0);
      send_bit(1'b0);
      chk("inv_err", {15'd0, err}, 16'd1);
      chk("inv_no_sym", {15'd0, valid_seen}, 16'd0);
      idle();
      chk("inv_err_pulse", {15'd0, err}, 16'd0);
      send_code("0100");
      chk("inv_recover_t", {7'd0, sym_valid, sym_out}, 16'h0174);
      idle();
      chk("inv_cnt", sym_cnt, 16'd7);

      // clr after two bits of 't'; the bit in the clr cycle is dropped
      send_code("01");
      clr = 1'b1;
      bit_in = 1'b0;
      bit_valid = 1'b1;
      idle();
      clr = 1'b0;
      bit_valid = 1'b0;
      chk("clr_no_sym", {15'd0, sym_valid}, 16'd0);
      send_code("0100");
      chk("clr_then_t", {7'd0, sym_valid, sym_out}, 16'h0174);
      idle();
      chk("clr_cnt", sym_cnt, 16'd8);

      // All 27 symbols back-to-back
      for (int i = 0; i < 27; i++) begin
         exp_ascii = (i == 26) ? 8'h20 : 8'(8'h61 + i);
         send_code(codes[i]);
         chk($sformatf("loop_%0d", i), {7'd0, sym_valid, sym_out}, {7'd0, 1'b1, exp_ascii});
      end
      idle();
      chk("loop_cnt", sym_cnt, 16'd35);

      // Asynchronous reset mid-codeword
      send_code("11");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_outputs", {err, sym_valid, bit_ready, 5'd0, sym_out}, 16'h0000);
      chk("arst_cnt", sym_cnt, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      chk("arst_bit_ready", {15'd0, bit_ready}, 16'd1);
      send_code("001");
      chk("arst_then_e", {7'd0, sym_valid, sym_out}, 16'h0165);
      idle();
      chk("arst_cnt_after", sym_cnt, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
